dmem_hs: RTL

- Parametrised, handshaked successor of the single-cycle data-memory behavioural model; sits between LoadStoreUnit and backing storage.
- Adds configurable data/address width and depth, programmable access latency, external stall injection, out-of-range error response, and access counters.
- Used so the pipeline's memory-stall path can be exercised in simulation.

---
 rtl/dmem_hs.sv | 101 ++++++++++
 1 files changed

// File: rtl/dmem_hs.sv
// Handshaked data memory: latched request, programmable access latency with stall
// freeze, read-before-write response, out-of-range error and access counters.
module dmem_hs #(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 16,
  parameter  int DEPTH   = 65536,
  parameter  int LATENCY = 1,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BE_W-1:0]   req_we,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  a_addr;
  logic [BE_W-1:0]    a_we;
  logic [DATA_W-1:0]  a_wdata;
  logic               commit;
  logic               accept;
  logic               in_range;
  logic [IDX_W-1:0]   idx;

  // Contents survive reset; only the time-0 value is defined.
  logic [DATA_W-1:0]  mem [DEPTH] = '{default: '0};

  always_comb begin
    commit    = (state == WAIT) && (cnt == CNT_W'(1)) && !stall;
    req_ready = (state == IDLE) || commit;
    accept    = req_valid && req_ready;
    in_range  = {1'b0, a_addr} < DEPTH_L;
    idx       = a_addr[IDX_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_addr    <= '0;
      a_we      <= '0;
      a_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (commit) begin
        rsp_valid <= 1'b1;
        if (in_range) begin
          rsp_rdata <= mem[idx];
          rsp_err   <= 1'b0;
          if (|a_we) wr_count <= wr_count + 32'd1;
          else       rd_count <= rd_count + 32'd1;
        end else begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
      // A request accepted on the commit edge replaces the one just retired.
      if (accept) begin
        state   <= WAIT;
        cnt     <= CNT_W'(LATENCY);
        a_addr  <= req_addr;
        a_we    <= req_we;
        a_wdata <= req_wdata;
      end else if (commit) begin
        state <= IDLE;
      end else if (state == WAIT && !stall) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && in_range && !rst) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (a_we[b]) mem[idx][8*b +: 8] <= a_wdata[8*b +: 8];
      end
    end
  end

endmodule
